// File: rtl/wb_bus_arbiter_if.sv
// Bundles the NM master-side Wishbone buses and the shared slave port of the arbiter.
// "master" is the arbiter's view (bus master of the shared slave); "slave" is the opposite side.
interface wb_bus_arbiter_if #(
  parameter int NM = 2,
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [NM-1:0]    wbm_cyc_i;
  logic [NM-1:0]    wbm_stb_i;
  logic [NM-1:0]    wbm_we_i;
  logic [NM*AW-1:0] wbm_adr_i;
  logic [NM*DW-1:0] wbm_dat_i;
  logic [NM*4-1:0]  wbm_sel_i;
  logic [NM*3-1:0]  wbm_cti_i;
  logic [NM*2-1:0]  wbm_bte_i;
  logic [NM-1:0]    wbm_ack_o;
  logic [NM-1:0]    wbm_err_o;
  logic [NM-1:0]    wbm_rty_o;
  logic [NM*DW-1:0] wbm_dat_o;

  logic             wbs_cyc_o;
  logic             wbs_stb_o;
  logic             wbs_we_o;
  logic [AW-1:0]    wbs_adr_o;
  logic [DW-1:0]    wbs_dat_o;
  logic [3:0]       wbs_sel_o;
  logic [2:0]       wbs_cti_o;
  logic [1:0]       wbs_bte_o;
  logic             wbs_ack_i;
  logic             wbs_err_i;
  logic             wbs_rty_i;
  logic [DW-1:0]    wbs_dat_i;

  modport master (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
    output wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o,
    input  wbs_ack_i, wbs_err_i, wbs_rty_i, wbs_dat_i
  );

  modport slave (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
    input  wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o,
    output wbs_ack_i, wbs_err_i, wbs_rty_i, wbs_dat_i
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// NM-to-1 Wishbone arbiter (fixed priority or round-robin) with slave-response timeout.
// Grant registered 1 cycle after request; bus/responses then pass combinationally, owner held until it drops cyc.
module wb_bus_arbiter #(
  parameter int NM  = 2,
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int TMO = 255
) (
  input  logic              clk_int,
  input  logic              rst,
  input  logic              round_or_priority,
  wb_bus_arbiter_if.master  bus,
  output logic [NM-1:0]     grant_o,
  output logic              timeout_o
);
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [7:0] TMO_C = 8'(TMO);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR, S_DRAIN} state_t;

  state_t        r_state, w_next;
  logic [NM-1:0] r_grant;
  logic [IW-1:0] r_owner, r_last, w_win;
  logic [7:0]    r_cnt;
  logic          w_any_req, w_own_cyc, w_own_stb, w_resp;

  assign w_own_cyc = bus.wbm_cyc_i[r_owner];
  assign w_own_stb = bus.wbm_stb_i[r_owner];
  assign w_resp    = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign grant_o   = r_grant;
  assign bus.wbm_dat_o = {NM{bus.wbs_dat_i}};

  // Round-robin scan starts just past the last owner; priority scan starts at 0.
  always_comb begin
    w_win     = '0;
    w_any_req = 1'b0;
    for (int i = 0; i < NM; i++) begin
      int idx;
      idx = round_or_priority ? (int'(r_last) + 1 + i) % NM : i;
      if (!w_any_req && bus.wbm_cyc_i[idx]) begin
        w_any_req = 1'b1;
        w_win     = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk_int or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_BUSY;
      S_BUSY: begin
        if (!w_own_cyc)                    w_next = S_IDLE;
        else if (!w_resp && r_cnt == TMO_C) w_next = S_ERR;
      end
      S_ERR:   w_next = S_DRAIN;
      S_DRAIN: if (!w_own_cyc) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_int or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= IW'(NM - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_any_req) begin
            r_grant <= NM'(1) << w_win;
            r_owner <= w_win;
            r_last  <= w_win;
          end
        end
        S_BUSY: begin
          if (!w_own_cyc)                    r_grant <= '0;
          if (w_resp)                         r_cnt <= '0;
          else if (w_own_stb && r_cnt != TMO_C) r_cnt <= r_cnt + 8'd1;
        end
        S_DRAIN: if (!w_own_cyc) r_grant <= '0;
        default: ;
      endcase
    end
  end

  // Slave port is driven only while an owner is actively in its cycle.
  always_comb begin
    bus.wbs_cyc_o = 1'b0;
    bus.wbs_stb_o = 1'b0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    bus.wbm_ack_o = '0;
    bus.wbm_err_o = '0;
    bus.wbm_rty_o = '0;
    timeout_o     = 1'b0;
    case (r_state)
      S_BUSY: begin
        bus.wbs_cyc_o = w_own_cyc;
        bus.wbs_stb_o = w_own_stb;
        bus.wbs_we_o  = bus.wbm_we_i[r_owner];
        bus.wbs_adr_o = bus.wbm_adr_i[int'(r_owner)*AW +: AW];
        bus.wbs_dat_o = bus.wbm_dat_i[int'(r_owner)*DW +: DW];
        bus.wbs_sel_o = bus.wbm_sel_i[int'(r_owner)*4 +: 4];
        bus.wbs_cti_o = bus.wbm_cti_i[int'(r_owner)*3 +: 3];
        bus.wbs_bte_o = bus.wbm_bte_i[int'(r_owner)*2 +: 2];
        bus.wbm_ack_o[r_owner] = bus.wbs_ack_i;
        bus.wbm_err_o[r_owner] = bus.wbs_err_i;
        bus.wbm_rty_o[r_owner] = bus.wbs_rty_i;
      end
      S_ERR: begin
        bus.wbm_err_o[r_owner] = 1'b1;
        timeout_o              = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: vector table, hand sequences for burst/timeout/reset, then random traffic vs a cycle model.
module tb_wb_bus_arbiter;
  localparam int NM = 2, DW = 32, AW = 32, TMO = 255;

  logic          clk_int = 1'b0;
  logic          rst;
  logic          mode;
  logic [NM-1:0] grant_o;
  logic          timeout_o;
  int            n_cmp = 0, n_bad = 0;

  wb_bus_arbiter_if #(.NM(NM), .DW(DW), .AW(AW)) bus();

  wb_bus_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TMO(TMO)) dut (
    .clk_int(clk_int), .rst(rst), .round_or_priority(mode),
    .bus(bus), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_int = ~clk_int;

  typedef struct {
    logic       md;
    logic [1:0] cyc;
    logic       ack;
    logic [1:0] e_gnt;
    logic       e_scyc;
    logic [1:0] e_ack;
  } vec_t;
  vec_t tv[16];

  // Cycle-level model state: current owner (-1 = none), last winner, unanswered strobe count.
  int m_owner, m_last, m_wait;
  bit m_err, m_drain;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_int);
    #1;
  endtask

  task automatic drv(input logic [NM-1:0] cyc, input logic [NM-1:0] stb, input logic ack);
    bus.wbm_cyc_i = cyc;
    bus.wbm_stb_i = stb;
    bus.wbs_ack_i = ack;
  endtask

  task automatic model_step(input logic [NM-1:0] cyc, input logic [NM-1:0] stb,
                            input logic resp, input logic md);
    if (m_owner < 0) begin
      for (int i = 1; i <= NM; i++) begin
        int j;
        j = md ? (m_last + i) % NM : i - 1;
        if (m_owner < 0 && cyc[j]) m_owner = j;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_wait = 0;
      end
    end else if (m_err) begin
      m_err   = 1'b0;
      m_drain = 1'b1;
    end else if (m_drain) begin
      if (!cyc[m_owner]) begin
        m_owner = -1;
        m_drain = 1'b0;
      end
    end else if (!cyc[m_owner]) m_owner = -1;
    else if (resp)               m_wait = 0;
    else if (m_wait == TMO)      m_err = 1'b1;
    else if (stb[m_owner])       m_wait++;
  endtask

  initial begin
    int t0, t1;
    bit seen;
    logic [NM-1:0] r_cyc, r_stb;
    logic [AW-1:0] adr [NM];
    logic          busy;
    logic [NM-1:0] e_bit;

    tv[0]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    tv[1]  = '{1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tv[2]  = '{1'b0, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    tv[3]  = '{1'b0, 2'b10, 1'b0, 2'b01, 1'b0, 2'b00};
    tv[4]  = '{1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00};
    tv[5]  = '{1'b0, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
    tv[6]  = '{1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00};
    tv[7]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
    tv[8]  = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tv[9]  = '{1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    tv[10] = '{1'b1, 2'b10, 1'b0, 2'b01, 1'b0, 2'b00};
    tv[11] = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tv[12] = '{1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
    tv[13] = '{1'b1, 2'b01, 1'b0, 2'b10, 1'b0, 2'b00};
    tv[14] = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    tv[15] = '{1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01};

    rst = 1'b1;
    mode = 1'b0;
    drv('0, '0, 1'b0);
    bus.wbm_we_i = '0;
    bus.wbm_sel_i = '1;
    bus.wbm_cti_i = '0;
    bus.wbm_bte_i = '0;
    bus.wbm_dat_i = {32'h1111_1111, 32'h0000_0000};
    bus.wbm_adr_i = {32'hB000_0001, 32'hA000_0000};
    bus.wbs_err_i = 1'b0;
    bus.wbs_rty_i = 1'b0;
    bus.wbs_dat_i = 32'hCAFE_F00D;

    // Reset state
    step();
    step();
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_scyc", 64'(bus.wbs_cyc_o), 64'd0);
    chk("rst_tmo", 64'(timeout_o), 64'd0);
    chk("rst_merr", 64'(bus.wbm_err_o), 64'd0);
    rst = 1'b0;

    // Vector table: priority then round-robin arbitration
    for (int i = 0; i < 16; i++) begin
      step();
      mode = tv[i].md;
      drv(tv[i].cyc, tv[i].cyc, tv[i].ack);
      #1;
      chk($sformatf("tv%0d_grant", i), 64'(grant_o), 64'(tv[i].e_gnt));
      chk($sformatf("tv%0d_scyc", i), 64'(bus.wbs_cyc_o), 64'(tv[i].e_scyc));
      chk($sformatf("tv%0d_ack", i), 64'(bus.wbm_ack_o), 64'(tv[i].e_ack));
    end
    step();
    drv('0, '0, 1'b0);
    step();

    // Burst by m1 is not preempted by lower-index m0 in priority mode
    mode = 1'b0;
    drv(2'b10, 2'b10, 1'b0);
    for (int b = 0; b < 4; b++) begin
      logic [2:0] cti;
      step();
      cti = (b == 3) ? 3'b111 : 3'b010;
      bus.wbm_cti_i = {cti, 3'b000};
      drv(2'b11, 2'b11, 1'b1);
      #1;
      chk($sformatf("burst%0d_grant", b), 64'(grant_o), 64'(2'b10));
      chk($sformatf("burst%0d_ack", b), 64'(bus.wbm_ack_o), 64'(2'b10));
      chk($sformatf("burst%0d_cti", b), 64'(bus.wbs_cti_o), 64'(cti));
    end
    step();
    drv(2'b01, 2'b01, 1'b0);
    bus.wbm_cti_i = '0;
    step();
    step();
    #1;
    chk("burst_next_grant", 64'(grant_o), 64'(2'b01));
    drv('0, '0, 1'b0);
    step();
    step();

    // Timeout: no slave response, m1 also waiting
    drv(2'b11, 2'b11, 1'b0);
    t0 = -1;
    t1 = -1;
    for (int c = 0; c < 400; c++) begin
      step();
      #1;
      if (bus.wbs_stb_o && t0 < 0) t0 = c;
      if (timeout_o) begin
        t1 = c;
        chk("tmo_merr", 64'(bus.wbm_err_o), 64'(2'b01));
        chk("tmo_scyc", 64'(bus.wbs_cyc_o), 64'd0);
        break;
      end
    end
    chk("tmo_latency", 64'(t1 - t0), 64'd256);
    for (int c = 0; c < 5; c++) step();
    #1;
    chk("drain_grant", 64'(grant_o), 64'(2'b01));
    chk("drain_scyc", 64'(bus.wbs_cyc_o), 64'd0);
    chk("drain_tmo", 64'(timeout_o), 64'd0);
    drv(2'b10, 2'b10, 1'b0);
    step();
    step();
    step();
    #1;
    chk("post_tmo_grant", 64'(grant_o), 64'(2'b10));
    drv('0, '0, 1'b0);
    step();
    step();

    // Ack on the cycle the counter reaches its limit
    drv(2'b01, 2'b01, 1'b0);
    t0 = -1;
    for (int c = 0; c < 10 && t0 < 0; c++) begin
      step();
      #1;
      if (bus.wbs_stb_o) t0 = c;
    end
    chk("ack_tmo_start", 64'(t0 >= 0), 64'd1);
    seen = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      step();
      if (k == 255) bus.wbs_ack_i = 1'b1;
      #1;
      if (timeout_o) seen = 1'b1;
    end
    chk("ack_tmo_ack", 64'(bus.wbm_ack_o), 64'(2'b01));
    step();
    bus.wbs_ack_i = 1'b0;
    #1;
    if (timeout_o) seen = 1'b1;
    chk("ack_tmo_no_timeout", 64'(seen), 64'd0);
    chk("ack_tmo_busy", 64'(bus.wbs_cyc_o), 64'd1);
    drv('0, '0, 1'b0);
    step();
    step();

    // Reset mid-transaction, then m0 wins first in both modes
    for (int md = 1; md >= 0; md--) begin
      mode = md[0];
      drv(2'b01, 2'b01, 1'b1);
      step();
      step();
      #1;
      chk($sformatf("rst%0d_pre_ack", md), 64'(bus.wbm_ack_o), 64'(2'b01));
      #1;
      rst = 1'b1;
      #1;
      chk($sformatf("rst%0d_grant", md), 64'(grant_o), 64'd0);
      chk($sformatf("rst%0d_scyc", md), 64'(bus.wbs_cyc_o), 64'd0);
      chk($sformatf("rst%0d_ack", md), 64'(bus.wbm_ack_o), 64'd0);
      step();
      rst = 1'b0;
      drv(2'b11, 2'b11, 1'b0);
      step();
      #1;
      chk($sformatf("rst%0d_first_grant", md), 64'(grant_o), 64'(2'b01));
      drv('0, '0, 1'b0);
      step();
      step();
    end

    // Random traffic against the model
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_owner = -1;
    m_last = NM - 1;
    m_wait = 0;
    m_err = 1'b0;
    m_drain = 1'b0;
    r_cyc = '0;
    r_stb = '0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(49) == 0) mode = ~mode;
      for (int k = 0; k < NM; k++) begin
        if (r_cyc[k]) begin
          if ($urandom_range(3) == 0) r_cyc[k] = 1'b0;
        end else if ($urandom_range(2) == 0) r_cyc[k] = 1'b1;
        r_stb[k] = r_cyc[k] & ($urandom_range(3) != 0);
        adr[k] = AW'($urandom());
        bus.wbm_adr_i[k*AW +: AW] = adr[k];
      end
      bus.wbm_cyc_i = r_cyc;
      bus.wbm_stb_i = r_stb;
      bus.wbs_ack_i = ($urandom_range(1) == 0);
      bus.wbs_err_i = ($urandom_range(15) == 0);
      bus.wbs_rty_i = ($urandom_range(15) == 0);
      #1;
      busy  = (m_owner >= 0) && !m_err && !m_drain;
      e_bit = (m_owner >= 0) ? NM'(1 << m_owner) : '0;
      chk("rnd_grant", 64'(grant_o), 64'(e_bit));
      chk("rnd_scyc", 64'(bus.wbs_cyc_o), 64'(busy && r_cyc[m_owner]));
      chk("rnd_sstb", 64'(bus.wbs_stb_o), 64'(busy && r_stb[m_owner]));
      chk("rnd_sadr", 64'(bus.wbs_adr_o), busy ? 64'(adr[m_owner]) : 64'd0);
      chk("rnd_ack", 64'(bus.wbm_ack_o), (busy && bus.wbs_ack_i) ? 64'(e_bit) : 64'd0);
      chk("rnd_err", 64'(bus.wbm_err_o), ((busy && bus.wbs_err_i) || m_err) ? 64'(e_bit) : 64'd0);
      chk("rnd_rty", 64'(bus.wbm_rty_o), (busy && bus.wbs_rty_i) ? 64'(e_bit) : 64'd0);
      chk("rnd_tmo", 64'(timeout_o), 64'(m_err));
      model_step(r_cyc, r_stb, bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i, mode);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
